// File: rtl/load_store_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | load_store_unit: RV32I sub-word load/store sequencer (RMW for SB/SH)  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module load_store_unit (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic        i_isStore,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_storeData,
  output logic        o_done,
  output logic [31:0] o_loadData,
  output logic        o_misaligned,
  output logic [31:0] o_memAddress,
  output logic        o_memWriteEnable,
  output logic [31:0] o_memWriteData,
  input  logic [31:0] i_memReadData
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      r_state, w_next;
  logic        r_isStore, r_err;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr, r_storeData, r_word;

  logic        w_accept, w_err, w_misaligned, w_illegal;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_sbWord, w_shWord, w_loadData;

  assign w_accept = i_valid && (r_state == IDLE);

  always_comb begin
    w_misaligned = 1'b0;
    w_illegal    = 1'b0;
    case (i_funct3[1:0])
      2'b01:   w_misaligned = i_addr[0];
      2'b10:   w_misaligned = (i_addr[1:0] != 2'b00);
      default: w_misaligned = 1'b0;
    endcase
    if (i_isStore)
      w_illegal = !(i_funct3 == 3'b000 || i_funct3 == 3'b001 || i_funct3 == 3'b010);
    else
      w_illegal = (i_funct3 == 3'b011 || i_funct3 == 3'b110 || i_funct3 == 3'b111);
    w_err = w_misaligned || w_illegal;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (w_err)                                w_next = RESP;
          else if (i_isStore && i_funct3 == 3'b010) w_next = WRITE;
          else                                      w_next = READ;
        end
      end
      READ:    w_next = r_isStore ? WRITE : RESP;
      WRITE:   w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_isStore   <= 1'b0;
      r_err       <= 1'b0;
      r_funct3    <= 3'b000;
      r_addr      <= 32'd0;
      r_storeData <= 32'd0;
      r_word      <= 32'd0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_isStore   <= i_isStore;
        r_funct3    <= i_funct3;
        r_addr      <= i_addr;
        r_storeData <= i_storeData;
        r_err       <= w_err;
      end
      if (r_state == READ)
        r_word <= i_memReadData;
    end
  end

  // Lane selection and merge work from the captured word and latched address only.
  always_comb begin
    w_byte   = r_word[{r_addr[1:0], 3'b000} +: 8];
    w_half   = r_addr[1] ? r_word[31:16] : r_word[15:0];
    w_sbWord = r_word;
    w_sbWord[{r_addr[1:0], 3'b000} +: 8] = r_storeData[7:0];
    w_shWord = r_addr[1] ? {r_storeData[15:0], r_word[15:0]}
                         : {r_word[31:16], r_storeData[15:0]};
    case (r_funct3)
      3'b000:  w_loadData = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_loadData = {{16{w_half[15]}}, w_half};
      3'b010:  w_loadData = r_word;
      3'b100:  w_loadData = {24'd0, w_byte};
      3'b101:  w_loadData = {16'd0, w_half};
      default: w_loadData = 32'd0;
    endcase
  end

  always_comb begin
    case (r_funct3[1:0])
      2'b10:   o_memWriteData = r_storeData;
      2'b01:   o_memWriteData = w_shWord;
      default: o_memWriteData = w_sbWord;
    endcase
  end

  assign o_ready          = (r_state == IDLE);
  assign o_done           = (r_state == RESP);
  assign o_misaligned     = (r_state == RESP) && r_err;
  assign o_loadData       = ((r_state == RESP) && !r_isStore && !r_err) ? w_loadData : 32'd0;
  assign o_memAddress     = {r_addr[31:2], 2'b00};
  assign o_memWriteEnable = (r_state == WRITE) && !i_rst;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_load_store_unit: directed self-checking bench for load_store_unit |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid, isStore;
  logic [2:0]  funct3;
  logic [31:0] addr, storeData;
  logic        ready, done, misaligned, memWe;
  logic [31:0] loadData, memAddr, memWd, memRd;

  logic [31:0] mem [0:63];
  logic        pre_en;
  logic [5:0]  pre_idx;
  logic [31:0] pre_data;
  int          wr_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready),
    .i_isStore(isStore), .i_funct3(funct3), .i_addr(addr), .i_storeData(storeData),
    .o_done(done), .o_loadData(loadData), .o_misaligned(misaligned),
    .o_memAddress(memAddr), .o_memWriteEnable(memWe), .o_memWriteData(memWd),
    .i_memReadData(memRd)
  );

  assign memRd = mem[memAddr[7:2]];

  initial wr_cnt = 0;
  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_data;
    else if (memWe) begin
      mem[memAddr[7:2]] <= memWd;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one request and watch it through to completion.
  task automatic req(input string tag, input logic st, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] d, input int exp_lat,
                     input logic [31:0] exp_ld, input logic exp_mis, input int exp_wr);
    int lat;
    int w0;
    logic [31:0] ld;
    logic mis;
    lat = 0; ld = 32'hX; mis = 1'bX;
    w0 = wr_cnt;
    valid = 1'b1; isStore = st; funct3 = f3; addr = a; storeData = d;
    @(posedge clk); #1;
    valid = 1'b0; isStore = 1'b0; funct3 = 3'b111; addr = 32'hFFFF_FFFF; storeData = 32'h5A5A_5A5A;
    chk({tag, " ready_low"}, {31'd0, ready}, 32'd0);
    for (int n = 1; n <= 6; n++) begin
      if (done) begin lat = n; ld = loadData; mis = misaligned; break; end
      @(posedge clk); #1;
    end
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " loadData"}, ld, exp_ld);
    chk({tag, " misaligned"}, {31'd0, mis}, {31'd0, exp_mis});
    chk({tag, " writes"}, wr_cnt - w0, exp_wr);
    @(posedge clk); #1;
  endtask

  logic [31:0] seq_a  [3];
  logic [2:0]  seq_f  [3];
  logic [31:0] seq_ld [3];

  initial begin
    rst = 1'b1; valid = 1'b0; isStore = 1'b0; funct3 = 3'b000; addr = 32'd0; storeData = 32'd0;
    pre_en = 1'b1; pre_idx = 6'd8; pre_data = 32'hDEADBEEF;
    @(posedge clk); #1;
    pre_idx = 6'd4; pre_data = 32'h11223344;
    @(posedge clk); #1;
    pre_idx = 6'd5; pre_data = 32'h0;
    @(posedge clk); #1;
    pre_en = 1'b0; rst = 1'b0;

    chk("rst ready", {31'd0, ready}, 32'd1);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst misaligned", {31'd0, misaligned}, 32'd0);
    chk("rst loadData", loadData, 32'd0);
    chk("rst memAddress", memAddr, 32'd0);
    chk("rst memWe", {31'd0, memWe}, 32'd0);
    chk("rst memWd", memWd, 32'd0);

    req("LB 21",  1'b0, 3'b000, 32'h21, 32'h0, 2, 32'hFFFFFFBE, 1'b0, 0);
    req("LBU 23", 1'b0, 3'b100, 32'h23, 32'h0, 2, 32'h000000DE, 1'b0, 0);
    req("LH 22",  1'b0, 3'b001, 32'h22, 32'h0, 2, 32'hFFFFDEAD, 1'b0, 0);
    req("LHU 20", 1'b0, 3'b101, 32'h20, 32'h0, 2, 32'h0000BEEF, 1'b0, 0);
    req("LW 20",  1'b0, 3'b010, 32'h20, 32'h0, 2, 32'hDEADBEEF, 1'b0, 0);

    req("SB 11", 1'b1, 3'b000, 32'h11, 32'hFFFFFFAB, 3, 32'h0, 1'b0, 1);
    chk("SB mem", mem[4], 32'h1122AB44);
    req("SH 12", 1'b1, 3'b001, 32'h12, 32'h0000CAFE, 3, 32'h0, 1'b0, 1);
    chk("SH mem", mem[4], 32'hCAFEAB44);
    req("SW 14", 1'b1, 3'b010, 32'h14, 32'h01020304, 2, 32'h0, 1'b0, 1);
    req("LW 14", 1'b0, 3'b010, 32'h14, 32'h0, 2, 32'h01020304, 1'b0, 0);

    req("LW 22 mis",  1'b0, 3'b010, 32'h22, 32'h0, 1, 32'h0, 1'b1, 0);
    req("SH 13 mis",  1'b1, 3'b001, 32'h13, 32'h0000BBBB, 1, 32'h0, 1'b1, 0);
    req("LD f3 011",  1'b0, 3'b011, 32'h20, 32'h0, 1, 32'h0, 1'b1, 0);
    req("SB f3 100",  1'b1, 3'b100, 32'h10, 32'h0, 1, 32'h0, 1'b1, 0);
    chk("err mem20", mem[8], 32'hDEADBEEF);
    chk("err mem10", mem[4], 32'hCAFEAB44);

    // Reset while the SB sits in WRITE.
    begin
      int w0;
      int dn;
      w0 = wr_cnt; dn = 0;
      valid = 1'b1; isStore = 1'b1; funct3 = 3'b000; addr = 32'h10; storeData = 32'h77;
      @(posedge clk); #1; valid = 1'b0;
      @(posedge clk); #1;
      chk("rstmid inWrite", {31'd0, memWe}, 32'd1);
      rst = 1'b1; #1;
      chk("rstmid we gated", {31'd0, memWe}, 32'd0);
      @(posedge clk); #1; rst = 1'b0;
      chk("rstmid ready", {31'd0, ready}, 32'd1);
      for (int n = 0; n < 4; n++) begin
        if (done) dn++;
        @(posedge clk); #1;
      end
      chk("rstmid no done", dn, 0);
      chk("rstmid no write", wr_cnt - w0, 0);
      chk("rstmid mem", mem[4], 32'hCAFEAB44);
    end

    // Hold valid high across three requests.
    begin
      int idx;
      int nd;
      logic acc;
      seq_a[0] = 32'h20; seq_f[0] = 3'b010; seq_ld[0] = 32'hDEADBEEF;
      seq_a[1] = 32'h21; seq_f[1] = 3'b100; seq_ld[1] = 32'h000000BE;
      seq_a[2] = 32'h14; seq_f[2] = 3'b010; seq_ld[2] = 32'h01020304;
      idx = 0; nd = 0;
      for (int c = 0; c < 20; c++) begin
        if (idx < 3) begin
          valid = 1'b1; isStore = 1'b0; funct3 = seq_f[idx]; addr = seq_a[idx];
        end else valid = 1'b0;
        acc = valid && ready;
        @(posedge clk); #1;
        if (acc) idx++;
        if (done) begin
          if (nd < 3) chk("b2b loadData", loadData, seq_ld[nd]);
          nd++;
        end
        if (nd >= 3 && idx >= 3) break;
      end
      valid = 1'b0;
      chk("b2b accepts", idx, 3);
      chk("b2b dones", nd, 3);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/load_store_unit.md
# load_store_unit

Sub-word load/store sequencer for the multi-cycle RISC-V core, placed between the controller/datapath and the unified word-addressed instruction/data memory. It accepts one load or store request at a time. It drives the memory's address, write-enable and write-data inputs and consumes its combinational word read data. It turns RV32I LB/LH/LW/LBU/LHU/SB/SH/SW into whole-word memory accesses, using read-modify-write for SB/SH, and returns extended load data with a one-cycle done pulse.

## Interface
- No parameters; data and address width fixed at 32.
- i_clk  input  1  clock; all state changes on rising edge.
- i_rst  input  1  reset; synchronous, active-high.
- i_valid  input  1  request present; accepted when i_valid && o_ready.
- o_ready  output  1  unit idle, can accept a request.
- i_isStore  input  1  1 = store, 0 = load.
- i_funct3  input  3  RV32I funct3 (load: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store: 000 SB, 001 SH, 010 SW).
- i_addr  input  32  byte address.
- i_storeData  input  32  rs2 value; low byte/half used for SB/SH.
- o_done  output  1  one-cycle pulse: request complete.
- o_loadData  output  32  extended load result; valid while o_done=1.
- o_misaligned  output  1  valid with o_done: request rejected (misaligned or illegal funct3).
- o_memAddress  output  32  word-aligned address to memory: {addr[31:2],2'b00}.
- o_memWriteEnable  output  1  memory write strobe.
- o_memWriteData  output  32  full word to write.
- i_memReadData  input  32  memory read word; combinational from o_memAddress.

## Operation
- FSM states: IDLE, READ, WRITE, RESP.
- IDLE: o_ready=1. On accept, latch isStore, funct3, addr, storeData. Check legality:
  - Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Illegal funct3: loads 011/110/111; stores other than 000/001/010.
  - On error: set the error flag and go to RESP.
  - Otherwise: SW goes to WRITE; all loads, SB and SH go to READ.
- READ: memory sees the latched word address. At the clock edge, capture i_memReadData into the word register. Loads then go to RESP; SB/SH go to WRITE.
- WRITE: o_memWriteEnable=1 for exactly this one cycle, then RESP. o_memWriteData is:
  - SW: storeData.
  - SB: captured word with byte lane addr[1:0] replaced by storeData[7:0].
  - SH: captured word with half lane addr[1] replaced by storeData[15:0].
- RESP: o_done=1, o_misaligned=error flag, then IDLE. o_loadData (0 for stores and errors) is:
  - LB/LBU: byte lane addr[1:0], sign/zero-extended.
  - LH/LHU: half lane addr[1], sign/zero-extended.
  - LW: the captured word.
- Lane numbering: little-endian; byte 0 = bits [7:0].
- Errors never assert o_memWriteEnable.
- o_memAddress holds its last latched value in IDLE and RESP.
- i_valid while not ready: ignored, not queued. Request inputs are sampled only on the accept edge; later changes have no effect.

## Timing
- Reset: state IDLE. Latched registers and word register 0. o_memAddress=0, o_done=0, o_misaligned=0, o_loadData=0, o_memWriteEnable=0, o_memWriteData=0, o_ready=1 on the first cycle after reset.
- o_memWriteEnable is gated by !i_rst, so no memory write occurs in any cycle with i_rst=1.
- Reset mid-operation aborts the request in any state: no done pulse, no subsequent write.
- Latency, from the accept edge to the cycle in which o_done=1:
  - Loads: 2 cycles.
  - SW: 2 cycles.
  - SB/SH: 3 cycles.
  - Error: 1 cycle.
- o_ready=0 from the cycle after accept through RESP inclusive. Back-to-back throughput is one request per latency+1 cycles.
- No combinational path from i_valid to memory outputs. o_memWriteEnable and o_memWriteData depend only on registered state.

## Test plan
- Preload word 0x20 = 0xDEADBEEF. Run LB 0x21, LBU 0x23, LH 0x22, LHU 0x20, LW 0x20 -> o_loadData 0xFFFFFFBE, 0x000000DE, 0xFFFFDEAD, 0x0000BEEF, 0xDEADBEEF; each o_done exactly 2 cycles after accept, o_misaligned=0.
- Word 0x10 = 0x11223344. SB addr 0x11 data 0xFFFFFFAB -> single write of 0x1122AB44 to 0x10, o_done 3 cycles after accept. Then SH 0x12 data 0xCAFE -> 0xCAFE AB44 written, i.e. word 0x10 = 0xCAFEAB44.
- SW 0x14 data 0x01020304 -> no READ state, one write, o_done 2 cycles after accept; LW 0x14 returns 0x01020304.
- LW 0x22, SH 0x13, load funct3 011 -> o_done 1 cycle after accept with o_misaligned=1, o_memWriteEnable never high, memory unchanged.
- Assert i_rst for one cycle while in WRITE of an SB -> no write occurs, no o_done, o_ready=1 on the next cycle, memory word unchanged.
- Hold i_valid high for three consecutive requests -> each accepted only when o_ready=1, no request lost or duplicated, completions in order.
